// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared types and constants for the sprite motion sequencer.
//   state_t      : sweep FSM states
//   SPR_*_ADDR   : sprite-core register addresses for the x0/y0 writes
//   GLB_*        : CPU global register addresses (run control, overrun clear)
package sprite_motion_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WR_X,
        WR_Y
    } state_t;

    localparam logic [13:0] SPR_X0_ADDR = 14'h2001;
    localparam logic [13:0] SPR_Y0_ADDR = 14'h2002;
    localparam logic [5:0]  GLB_RUN     = 6'h20;
    localparam logic [5:0]  GLB_CLR     = 6'h21;

endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Bus bundle between the CPU MMIO slot, the motion sequencer and the sprite cores.
//   cpu_cs/cpu_write/cpu_addr/cpu_wr_data : CPU slot write port
//   cpu_rd_data                           : status readback
//   slot_cs/slot_write/slot_addr/slot_wr_data : register writes toward the sprite cores
// master: the side driving the CPU slot (and observing the sprite bus).
// slave : the sequencer itself.
interface sprite_motion_ctrl_if #(
    parameter int unsigned N_SPRITE = 4
);
    import sprite_motion_pkg::*;

    logic                cpu_cs;
    logic                cpu_write;
    logic [5:0]          cpu_addr;
    logic [31:0]         cpu_wr_data;
    logic [31:0]         cpu_rd_data;
    logic [N_SPRITE-1:0] slot_cs;
    logic                slot_write;
    logic [13:0]         slot_addr;
    logic [31:0]         slot_wr_data;

    modport master (
        output cpu_cs, cpu_write, cpu_addr, cpu_wr_data,
        input  cpu_rd_data, slot_cs, slot_write, slot_addr, slot_wr_data
    );

    modport slave (
        input  cpu_cs, cpu_write, cpu_addr, cpu_wr_data,
        output cpu_rd_data, slot_cs, slot_write, slot_addr, slot_wr_data
    );

endinterface

// File: rtl/sprite_motion_ctrl_wrap_step.sv
// One-axis position step with screen wrap-around (combinational).
//   pos_i : current coordinate (0..MAX-1)
//   vel_i : signed 8-bit velocity
//   pos_o : (pos_i + vel_i) wrapped into 0..MAX-1
// |vel_i| <= 128 < MAX, so a single +/-MAX correction always suffices.
module sprite_wrap_step
    import sprite_motion_pkg::*;
#(
    parameter int MAX = 640
) (
    input  logic [10:0] pos_i,
    input  logic [7:0]  vel_i,
    output logic [10:0] pos_o
);

    localparam logic signed [12:0] MAX_S = 13'(MAX);

    logic signed [12:0] sum;
    logic signed [12:0] res;

    always_comb begin
        sum = signed'({2'b00, pos_i}) + signed'({{5{vel_i[7]}}, vel_i});
        if (sum >= MAX_S) begin
            res = sum - MAX_S;
        end else if (sum[12]) begin
            res = sum + MAX_S;
        end else begin
            res = sum;
        end
        pos_o = 11'(res);
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous motion sequencer for up to N_SPRITE sprite cores.
//   clk, reset  : system clock, asynchronous active-high reset
//   frame_start : one-cycle pulse at the start of blanking; starts a sweep when run=1
//   bus (slave) : CPU register port + status readback, sprite-core write bus
//   busy        : high for the 3*N_SPRITE cycles of a sweep
// Each sweep visits every sprite: CALC (step if enabled), WR_X, WR_Y.
module sprite_motion_ctrl
    import sprite_motion_pkg::*;
#(
    parameter int unsigned N_SPRITE = 4,
    parameter int unsigned H_MAX    = 640,
    parameter int unsigned V_MAX    = 480
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    sprite_motion_ctrl_if.slave  bus,
    output logic                 busy
);

    localparam int unsigned     IW       = (N_SPRITE > 1) ? $clog2(N_SPRITE) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N_SPRITE - 1);

    logic [10:0]         x_q  [N_SPRITE];
    logic [10:0]         x_d  [N_SPRITE];
    logic [10:0]         y_q  [N_SPRITE];
    logic [10:0]         y_d  [N_SPRITE];
    logic [7:0]          vx_q [N_SPRITE];
    logic [7:0]          vx_d [N_SPRITE];
    logic [7:0]          vy_q [N_SPRITE];
    logic [7:0]          vy_d [N_SPRITE];
    logic [N_SPRITE-1:0] en_q, en_d;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                run_q, run_d;
    logic [7:0]          ovr_q, ovr_d;

    logic [N_SPRITE-1:0] slot_cs_q, slot_cs_d;
    logic                slot_write_q, slot_write_d;
    logic [13:0]         slot_addr_q, slot_addr_d;
    logic [31:0]         slot_data_q, slot_data_d;

    logic [10:0]         x_step, y_step;
    logic                cpu_wr;

    assign cpu_wr = bus.cpu_cs & bus.cpu_write;

    sprite_wrap_step #(.MAX(int'(H_MAX))) u_wrap_x (
        .pos_i (x_q[idx_q]),
        .vel_i (vx_q[idx_q]),
        .pos_o (x_step)
    );

    sprite_wrap_step #(.MAX(int'(V_MAX))) u_wrap_y (
        .pos_i (y_q[idx_q]),
        .vel_i (vy_q[idx_q]),
        .pos_o (y_step)
    );

    // Register file: the sweep step is applied first, then a CPU write to the
    // same field overrides it, so the CPU value wins in the CALC cycle.
    always_comb begin
        en_d = en_q;
        for (int unsigned i = 0; i < N_SPRITE; i++) begin
            x_d[i]  = x_q[i];
            y_d[i]  = y_q[i];
            vx_d[i] = vx_q[i];
            vy_d[i] = vy_q[i];
            if (state_q == CALC && idx_q == IW'(i) && en_q[i]) begin
                x_d[i] = x_step;
                y_d[i] = y_step;
            end
            if (cpu_wr && !bus.cpu_addr[5] && bus.cpu_addr[4:2] == 3'(i)) begin
                case (bus.cpu_addr[1:0])
                    2'd0: en_d[i] = bus.cpu_wr_data[0];
                    2'd1: x_d[i]  = bus.cpu_wr_data[10:0];
                    2'd2: y_d[i]  = bus.cpu_wr_data[10:0];
                    default: begin
                        vx_d[i] = bus.cpu_wr_data[7:0];
                        vy_d[i] = bus.cpu_wr_data[15:8];
                    end
                endcase
            end
        end
    end

    always_comb begin
        run_d = run_q;
        ovr_d = ovr_q;
        if (cpu_wr && bus.cpu_addr == GLB_RUN) begin
            run_d = bus.cpu_wr_data[0];
        end
        if (frame_start && state_q != IDLE && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end
        if (cpu_wr && bus.cpu_addr == GLB_CLR) begin
            ovr_d = '0;
        end
    end

    // Slot outputs are registered on the edge entering WR_X/WR_Y and take the
    // post-edge register value, so a same-cycle CPU write is what gets emitted.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        slot_cs_d    = '0;
        slot_write_d = 1'b0;
        slot_addr_d  = '0;
        slot_data_d  = '0;
        case (state_q)
            IDLE: begin
                if (frame_start && run_q) begin
                    state_d = CALC;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                state_d      = WR_X;
                slot_cs_d    = N_SPRITE'(1) << idx_q;
                slot_write_d = 1'b1;
                slot_addr_d  = SPR_X0_ADDR;
                slot_data_d  = {21'b0, x_d[idx_q]};
            end
            WR_X: begin
                state_d      = WR_Y;
                slot_cs_d    = N_SPRITE'(1) << idx_q;
                slot_write_d = 1'b1;
                slot_addr_d  = SPR_Y0_ADDR;
                slot_data_d  = {21'b0, y_d[idx_q]};
            end
            default: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = CALC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SPRITE; i++) begin
                x_q[i]  <= '0;
                y_q[i]  <= '0;
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
            en_q         <= '0;
            state_q      <= IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            run_q        <= 1'b0;
            ovr_q        <= '0;
            slot_cs_q    <= '0;
            slot_write_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_SPRITE; i++) begin
                x_q[i]  <= x_d[i];
                y_q[i]  <= y_d[i];
                vx_q[i] <= vx_d[i];
                vy_q[i] <= vy_d[i];
            end
            en_q         <= en_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            run_q        <= run_d;
            ovr_q        <= ovr_d;
            slot_cs_q    <= slot_cs_d;
            slot_write_q <= slot_write_d;
            slot_addr_q  <= slot_addr_d;
            slot_data_q  <= slot_data_d;
        end
    end

    assign busy             = busy_q;
    assign bus.cpu_rd_data  = {16'b0, ovr_q, 6'b0, run_q, busy_q};
    assign bus.slot_cs      = slot_cs_q;
    assign bus.slot_write   = slot_write_q;
    assign bus.slot_addr    = slot_addr_q;
    assign bus.slot_wr_data = slot_data_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: sweeps are predicted from a
// modulo-arithmetic position model and checked by an independent slot monitor.
module tb_sprite_motion_ctrl;
    import sprite_motion_pkg::*;

    localparam int N = 4;
    localparam int H = 640;
    localparam int V = 480;

    logic clk = 1'b0;
    logic reset;
    logic frame_start;
    logic busy;

    sprite_motion_ctrl_if #(.N_SPRITE(N)) bus ();

    sprite_motion_ctrl #(.N_SPRITE(N), .H_MAX(H), .V_MAX(V)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  cs;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sbq[$];
    int  checks   = 0;
    int  failures = 0;

    int  mx [N];
    int  my [N];
    int  mvx[N];
    int  mvy[N];
    bit  men[N];
    int  m_ovr;
    bit  m_run;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wrapm(input int p, input int v, input int m);
        return ((p + v) % m + m) % m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 0; mvx[i] = 0; mvy[i] = 0; men[i] = 0;
        end
        m_ovr = 0;
        m_run = 0;
    endtask

    // Predict a full sweep; cpu_i >= 0 means the CPU overwrites that sprite's x in its step cycle.
    task automatic model_sweep(input int cpu_i, input int cpu_x);
        wr_t e;
        for (int i = 0; i < N; i++) begin
            if (men[i]) begin
                mx[i] = wrapm(mx[i], mvx[i], H);
                my[i] = wrapm(my[i], mvy[i], V);
            end
            if (i == cpu_i) mx[i] = cpu_x;
            e.cs = 4'(1 << i); e.addr = SPR_X0_ADDR; e.data = 32'(mx[i]);
            sbq.push_back(e);
            e.addr = SPR_Y0_ADDR; e.data = 32'(my[i]);
            sbq.push_back(e);
        end
    endtask

    // Monitor: every cycle either pops an expected write or requires an idle bus.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.slot_write) begin
                if (sbq.size() == 0) begin
                    check("slot_unexpected", {bus.slot_cs, bus.slot_addr, bus.slot_wr_data}, 64'd0);
                end else begin
                    wr_t e;
                    e = sbq.pop_front();
                    check("slot_write", {bus.slot_cs, bus.slot_addr, bus.slot_wr_data}, e);
                end
            end else begin
                check("slot_idle", {bus.slot_cs, bus.slot_addr, bus.slot_wr_data}, 64'd0);
            end
        end
    end

    task automatic cpu_wr(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cpu_cs = 1'b1; bus.cpu_write = 1'b1; bus.cpu_addr = a; bus.cpu_wr_data = d;
        @(negedge clk);
        bus.cpu_cs = 1'b0; bus.cpu_write = 1'b0;
    endtask

    task automatic set_en(input int i, input bit e);
        cpu_wr({1'b0, 3'(i), 2'd0}, {31'b0, e});
        if (i < N) men[i] = e;
    endtask
    task automatic set_x(input int i, input int v);
        cpu_wr({1'b0, 3'(i), 2'd1}, 32'(v));
        if (i < N) mx[i] = v;
    endtask
    task automatic set_y(input int i, input int v);
        cpu_wr({1'b0, 3'(i), 2'd2}, 32'(v));
        if (i < N) my[i] = v;
    endtask
    task automatic set_v(input int i, input int vx, input int vy);
        cpu_wr({1'b0, 3'(i), 2'd3}, {16'b0, 8'(vy), 8'(vx)});
        if (i < N) begin mvx[i] = vx; mvy[i] = vy; end
    endtask
    task automatic set_run(input bit r);
        cpu_wr(GLB_RUN, {31'b0, r});
        m_run = r;
    endtask

    task automatic check_status(input string nm);
        @(negedge clk);
        check(nm, bus.cpu_rd_data, {16'b0, 8'(m_ovr), 6'b0, m_run, 1'b0});
    endtask

    // One sweep; extra_at>0 re-pulses frame_start in that busy cycle,
    // cpu_i>=0 writes x=cpu_x to sprite cpu_i during its step cycle.
    task automatic sweep(input int extra_at, input int cpu_i, input int cpu_x);
        int cnt;
        model_sweep(cpu_i, cpu_x);
        if (extra_at > 0 && m_ovr < 255) m_ovr++;
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            frame_start = (cnt == extra_at);
            if (cpu_i >= 0 && cnt == 3 * cpu_i + 1) begin
                bus.cpu_cs = 1'b1; bus.cpu_write = 1'b1;
                bus.cpu_addr = {1'b0, 3'(cpu_i), 2'd1}; bus.cpu_wr_data = 32'(cpu_x);
            end else begin
                bus.cpu_cs = 1'b0; bus.cpu_write = 1'b0;
            end
            @(negedge clk);
        end
        frame_start = 1'b0; bus.cpu_cs = 1'b0; bus.cpu_write = 1'b0;
        check("busy_cycles", 64'(cnt), 64'd12);
        @(negedge clk);
        check("sweep_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1; frame_start = 1'b0;
        bus.cpu_cs = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_status", bus.cpu_rd_data, 64'd0);
        check("reset_slot", {bus.slot_cs, bus.slot_write, bus.slot_addr, bus.slot_wr_data}, 64'd0);
        reset = 1'b0;

        // Basic step: expect 105 / 197 on sprite 0
        set_en(0, 1'b1); set_x(0, 100); set_y(0, 200); set_v(0, 5, -3);
        set_run(1'b1);
        check_status("status_run");
        sweep(0, -1, 0);

        // Wrap cases
        set_y(0, 478); set_v(0, 0, 5);
        set_en(1, 1'b1); set_x(1, 2); set_v(1, -7, 0);
        set_en(2, 1'b1); set_x(2, 639); set_v(2, 1, 0);
        sweep(0, -1, 0);

        // Disabled sprite keeps and re-emits its position
        set_en(2, 1'b0); set_x(2, 50);
        sweep(0, -1, 0);
        sweep(0, -1, 0);

        // Writes to a nonexistent sprite are ignored
        set_x(5, 999); set_en(7, 1'b1);
        sweep(0, -1, 0);

        // Overrun counting and clear
        sweep(4, -1, 0);
        check_status("status_ovr1");
        cpu_wr(GLB_CLR, 32'd0); m_ovr = 0;
        check_status("status_ovr_clr");

        // CPU x write in sprite 1's step cycle wins
        sweep(0, 1, 300);

        // run=0: frame_start produces no sweep
        set_run(1'b0);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check("norun_busy", 64'(busy), 64'd0);
        check_status("status_norun");

        // Reset during WR_X
        set_run(1'b1);
        model_sweep(-1, 0);
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (bus.slot_write && bus.slot_addr == SPR_X0_ADDR) found = 1'b1;
            else @(negedge clk);
        end
        check("wrx_reached", 64'(found), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_slot_cs", 64'(bus.slot_cs), 64'd0);
        check("rst_slot_write", 64'(bus.slot_write), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_status", bus.cpu_rd_data, 64'd0);
        sbq.delete();
        model_reset();
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < N; i++) set_en(i, 1'b1);
        set_run(1'b1);
        sweep(0, -1, 0);

        // Randomized sweeps
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                set_en(i, 1'($urandom_range(0, 1)));
                set_x(i, int'($urandom_range(0, H - 1)));
                set_y(i, int'($urandom_range(0, V - 1)));
                set_v(i, int'($urandom_range(0, 254)) - 127, int'($urandom_range(0, 254)) - 127);
            end
            sweep(0, -1, 0);
            sweep(0, -1, 0);
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
